// File: rtl/base_agate_cnt.sv
// Multi-channel valid/ready gate. Each channel passes while open or while its
// loaded transaction budget is non-zero, and closes once the budget is spent.
module base_agate_cnt #(
  parameter int unsigned width  = 1,
  parameter int unsigned cwidth = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [width-1:0]  open,
  input  logic [width-1:0]  ld_v,
  input  logic [cwidth-1:0] ld_cnt,
  input  logic [width-1:0]  i_v,
  output logic [width-1:0]  i_r,
  output logic [width-1:0]  o_v,
  input  logic [width-1:0]  o_r,
  output logic [width-1:0]  cnt_nz,
  output logic [width-1:0]  done
);

  logic [width-1:0][cwidth-1:0] cnt_q, cnt_d;
  logic [width-1:0]             done_q, done_d;
  logic [width-1:0]             pass;
  logic [width-1:0]             xfer;

  // Gating is purely combinational so the gate adds no latency to the stream.
  always_comb begin
    for (int c = 0; c < int'(width); c++) begin
      cnt_nz[c] = (cnt_q[c] != '0);
    end
    pass = open | cnt_nz;
    o_v  = pass & i_v;
    i_r  = pass & o_r;
    xfer = pass & i_v & o_r;
    done = done_q;
  end

  // Load beats decrement; transfers under open leave the budget untouched.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = '0;
    for (int c = 0; c < int'(width); c++) begin
      if (ld_v[c]) begin
        cnt_d[c] = ld_cnt;
      end else if (xfer[c] && !open[c] && cnt_nz[c]) begin
        cnt_d[c]  = cnt_q[c] - cwidth'(1);
        done_d[c] = (cnt_q[c] == cwidth'(1));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      done_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_base_agate_cnt.sv
// Scoreboard bench for base_agate_cnt: per-cycle directed vectors push their
// hand-computed expectations, a negedge monitor pops and compares them.
module tb_base_agate_cnt;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          reset;
  logic [W-1:0]  open, ld_v, i_v, o_r;
  logic [CW-1:0] ld_cnt;
  logic [W-1:0]  i_r, o_v, cnt_nz, done;

  base_agate_cnt #(.width(W), .cwidth(CW)) dut (
    .clk(clk), .reset(reset), .open(open), .ld_v(ld_v), .ld_cnt(ld_cnt),
    .i_v(i_v), .i_r(i_r), .o_v(o_v), .o_r(o_r), .cnt_nz(cnt_nz), .done(done)
  );

  typedef struct packed {
    int         id;
    logic [3:0] ov;
    logic [3:0] ir;
    logic [3:0] nz;
    logic [3:0] dn;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   row_id = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s row %0d: got %b expected %b", name, id, act, req);
    end
  endtask

  // Monitor: the DUT presents a new cycle of outputs every clock; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("o_v",    e.id, o_v,    e.ov);
      chk("i_r",    e.id, i_r,    e.ir);
      chk("cnt_nz", e.id, cnt_nz, e.nz);
      chk("done",   e.id, done,   e.dn);
    end
  end

  task automatic step(input logic rst, input logic [3:0] op, input logic [3:0] ld,
                      input logic [3:0] ldc, input logic [3:0] iv, input logic [3:0] orr,
                      input logic [3:0] ov, input logic [3:0] ir, input logic [3:0] nz,
                      input logic [3:0] dn);
    exp_t e;
    @(posedge clk);
    #1;
    reset  = rst;
    open   = op;
    ld_v   = ld;
    ld_cnt = ldc;
    i_v    = iv;
    o_r    = orr;
    row_id++;
    e.id = row_id; e.ov = ov; e.ir = ir; e.nz = nz; e.dn = dn;
    exp_q.push_back(e);
  endtask

  // Channel-0 row; channels 1..3 see valid and ready high but stay closed.
  task automatic c0(input logic rst, input logic op, input logic ld, input logic [3:0] ldc,
                    input logic orr, input logic ov, input logic ir, input logic nz,
                    input logic dn);
    step(rst, {3'b000, op}, {3'b000, ld}, ldc, 4'hF, {3'b111, orr},
         {3'b000, ov}, {3'b000, ir}, {3'b000, nz}, {3'b000, dn});
  endtask

  initial begin
    reset = 1'b1; open = '0; ld_v = '0; ld_cnt = '0; i_v = '0; o_r = '0;
    repeat (2) @(posedge clk);

    // reset held: closed, load ignored
    c0(1, 0, 1, 4'd5, 1, 0, 0, 0, 0);
    c0(0, 0, 0, 4'd0, 1, 0, 0, 0, 0);
    // budget 3 with continuous flow
    c0(0, 0, 1, 4'd3, 1, 0, 0, 0, 0);
    repeat (3) c0(0, 0, 0, 4'd0, 1, 1, 1, 1, 0);
    c0(0, 0, 0, 4'd0, 1, 0, 0, 0, 1);
    c0(0, 0, 0, 4'd0, 1, 0, 0, 0, 0);
    // budget 2 with ready toggling
    c0(0, 0, 1, 4'd2, 1, 0, 0, 0, 0);
    c0(0, 0, 0, 4'd0, 0, 1, 0, 1, 0);
    c0(0, 0, 0, 4'd0, 1, 1, 1, 1, 0);
    c0(0, 0, 0, 4'd0, 0, 1, 0, 1, 0);
    c0(0, 0, 0, 4'd0, 1, 1, 1, 1, 0);
    c0(0, 0, 0, 4'd0, 0, 0, 0, 0, 1);
    c0(0, 0, 0, 4'd0, 1, 0, 0, 0, 0);
    // last transfer overridden by a load of 5
    c0(0, 0, 1, 4'd1, 1, 0, 0, 0, 0);
    c0(0, 0, 1, 4'd5, 1, 1, 1, 1, 0);
    repeat (5) c0(0, 0, 0, 4'd0, 1, 1, 1, 1, 0);
    c0(0, 0, 0, 4'd0, 1, 0, 0, 0, 1);
    c0(0, 0, 0, 4'd0, 1, 0, 0, 0, 0);
    // budget 4 preserved across 10 open transfers
    c0(0, 0, 1, 4'd4, 1, 0, 0, 0, 0);
    repeat (10) c0(0, 1, 0, 4'd0, 1, 1, 1, 1, 0);
    repeat (4) c0(0, 0, 0, 4'd0, 1, 1, 1, 1, 0);
    c0(0, 0, 0, 4'd0, 1, 0, 0, 0, 1);
    // open with empty budget, then load of 0 gives no done
    c0(0, 1, 0, 4'd0, 1, 1, 1, 0, 0);
    c0(0, 0, 1, 4'd0, 1, 0, 0, 0, 0);
    c0(0, 0, 0, 4'd0, 1, 0, 0, 0, 0);
    // reload replaces rather than adds
    c0(0, 0, 1, 4'd3, 1, 0, 0, 0, 0);
    c0(0, 0, 1, 4'd2, 1, 1, 1, 1, 0);
    c0(0, 0, 0, 4'd0, 1, 1, 1, 1, 0);
    c0(0, 0, 0, 4'd0, 1, 1, 1, 1, 0);
    c0(0, 0, 0, 4'd0, 1, 0, 0, 0, 1);
    // load 0 while non-zero closes without done
    c0(0, 0, 1, 4'd5, 1, 0, 0, 0, 0);
    c0(0, 0, 1, 4'd0, 1, 1, 1, 1, 0);
    c0(0, 0, 0, 4'd0, 1, 0, 0, 0, 0);
    // independent channels 1 and 2, budget 2 each, ch2 stalled once
    step(0, 4'h0, 4'b0110, 4'd2, 4'hF, 4'hF,    4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'h0, 4'b0000, 4'd0, 4'hF, 4'b1011, 4'b0110, 4'b0010, 4'b0110, 4'b0000);
    step(0, 4'h0, 4'b0000, 4'd0, 4'hF, 4'hF,    4'b0110, 4'b0110, 4'b0110, 4'b0000);
    step(0, 4'h0, 4'b0000, 4'd0, 4'hF, 4'hF,    4'b0100, 4'b0100, 4'b0100, 4'b0010);
    step(0, 4'h0, 4'b0000, 4'd0, 4'hF, 4'hF,    4'b0000, 4'b0000, 4'b0000, 4'b0100);
    step(0, 4'h0, 4'b0000, 4'd0, 4'hF, 4'hF,    4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // budget 15 burst interrupted by an asynchronous reset
    c0(0, 0, 1, 4'd15, 1, 0, 0, 0, 0);
    c0(0, 0, 0, 4'd0, 1, 1, 1, 1, 0);
    c0(0, 0, 0, 4'd0, 1, 1, 1, 1, 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_o_v",    0, o_v,    4'b0000);
    chk("async_rst_i_r",    0, i_r,    4'b0000);
    chk("async_rst_cnt_nz", 0, cnt_nz, 4'b0000);
    chk("async_rst_done",   0, done,   4'b0000);
    @(negedge clk);
    #2;
    reset = 1'b0;
    c0(0, 0, 0, 4'd0, 1, 0, 0, 0, 0);
    c0(0, 0, 0, 4'd0, 1, 0, 0, 0, 0);
    c0(0, 0, 1, 4'd1, 1, 0, 0, 0, 0);
    c0(0, 0, 0, 4'd0, 1, 1, 1, 1, 0);
    c0(0, 0, 0, 4'd0, 1, 0, 0, 0, 1);

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/base_agate_cnt.md
Name: base_agate_cnt

Overview:
- Multi-channel valid/ready gate with a per-channel transaction budget counter.
- Each channel passes transfers while open, or while its loaded budget is non-zero; it closes automatically once the budget is consumed.
- Used for metered admission of bursts, credit-limited streams and one-shot drain windows.
- Sits inline on a valid/ready interface, between producer and consumer.

Parameters:
- width, 1: number of independent channels.
- cwidth, 8: budget counter width per channel; max budget = 2^cwidth-1.

Ports:
- clk  input  1  clock, all state rising-edge.
- reset  input  1  asynchronous, active-high reset.
- open  input  width  per-channel unlimited-pass override (combinational, no counting).
- ld_v  input  width  per-channel budget load strobe.
- ld_cnt  input  cwidth  budget value, shared by all channels strobed in the same cycle.
- i_v  input  width  upstream valid, per channel.
- i_r  output  width  upstream ready, per channel.
- o_v  output  width  downstream valid, per channel.
- o_r  input  width  downstream ready, per channel.
- cnt_nz  output  width  per-channel budget non-zero (registered state).
- done  output  width  one-cycle pulse when a channel's budget reaches zero through a transfer.

Behaviour:
- Per channel c: pass[c] = open[c] | cnt_nz[c]. Outputs are combinational from pass:
  - o_v[c] = pass[c] & i_v[c]
  - i_r[c] = pass[c] & o_r[c]
- No valid->ready or ready->valid combinational path is added beyond pass gating; latency is 0 cycles.
- Transfer xfer[c] = pass[c] & i_v[c] & o_r[c].
- Budget register cnt[c], cwidth bits. Priority per clock edge:
  1. ld_v[c]: cnt[c] <= ld_cnt. A load overrides any same-cycle decrement; a same-cycle transfer is still accepted under the old pass value.
  2. Else xfer[c] & ~open[c] & cnt[c]!=0: cnt[c] <= cnt[c]-1.
  3. Else hold.
- Transfers under open[c]=1 never decrement the budget. The budget is preserved and resumes counting when open[c] drops.
- Counter never underflows; no wrap-around at 0.
- cnt_nz[c] = (cnt[c] != 0), derived from the register.
- done[c] is registered. It is set for exactly one cycle in the cycle after a decrement takes cnt[c] from 1 to 0. It is not asserted by a load of 0, a load overriding the last transfer, or reset.
- Loading ld_cnt=0 closes the channel immediately from the next cycle, unless open is set.
- Loading while the budget is non-zero replaces the budget; it does not add to it.
- Channels are fully independent; there is no cross-channel arbitration.
- Reset (asynchronous, any time, including mid-burst):
  - cnt <= 0, done <= 0.
  - Hence cnt_nz=0; o_v=i_v&open and i_r=o_r&open.
  - Any in-progress budget is discarded.
- While reset is asserted, ld_v is ignored.
- Unknown or X on open/ld_v is not tolerated; inputs are assumed clean by the surrounding design.

Test Plan:
- Reset, open=0, i_v=1, o_r=1 on all channels -> o_v=0, i_r=0, cnt_nz=0, done=0 every cycle.
- width=1, load ld_cnt=3, hold i_v=o_r=1 -> exactly 3 transfers on consecutive cycles (o_v=1 for 3 cycles). cnt_nz falls after the 3rd edge. done pulses 1 cycle once, then o_v=0.
- Budget 2, toggle o_r 1,0,1,0,1 -> transfers only on o_r=1 cycles. Closes after the 2nd accepted transfer; o_v stays 0 afterward despite i_v=1.
- Budget 1 with the transfer and ld_cnt=5 in the same cycle -> transfer accepted, cnt=5 next cycle, no done pulse. 5 further transfers follow, then done.
- Budget 4, open=1 for 10 transfers, then open=0 -> cnt still 4. Exactly 4 more transfers, then closed with done.
- width=4, cwidth=4, channel 0 budget 15 streaming; assert reset mid-burst for 1 cycle -> all outputs drop asynchronously, cnt_nz=0, done=0. After reset, no transfers until a new load.
